// File: rtl/neuron_arbiter_pkg.sv
// Shared types and width helpers for the Neuron arbiter and its tag FIFO.
package neuron_arbiter_pkg;

    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // Neuron input beat: NC lanes, each holding a full-precision NP-input sum.
    function automatic int calc_iw(input int np, input int nc, input int wd);
        return nc * ($clog2(np) + 1 + wd);
    endfunction

    function automatic int calc_ow(input bit hidden, input int np, input int nc, input int wd);
        return hidden ? nc * wd : calc_iw(np, nc, wd);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_tag_fifo.sv
// Synchronous FIFO of requester indices, one entry per result in flight through the Neuron.
module neuron_tag_fifo
    import neuron_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer wrap is the natural PW-bit overflow.
    always_comb begin
        wr_d  = push_ok ? wr_q + PW'(1) : wr_q;
        rd_d  = pop_ok ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/neuron_arbiter.sv
// Round-robin sharing of one Neuron stage among NR accumulator lanes; results are
// steered back to their issuing lane through an in-order tag queue.
module neuron_arbiter
    import neuron_arbiter_pkg::*;
#(
    parameter int NR     = 2,
    parameter     HIDDEN = "yes",
    parameter int NP     = 4,
    parameter int NC     = 4,
    parameter int WD     = 4,
    parameter int TQ     = 2,
    localparam int IW    = calc_iw(NP, NC, WD),
    localparam int OW    = calc_ow(HIDDEN == "yes", NP, NC, WD)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [NR-1:0]    iValid_AS,
    output logic [NR-1:0]    oReady_AS,
    input  logic [NR*IW-1:0] iData_AS,
    output logic             oValid_NA,
    input  logic             iReady_NA,
    output logic [IW-1:0]    oData_NA,
    input  logic             iValid_NB,
    output logic             oReady_NB,
    input  logic [OW-1:0]    iData_NB,
    output logic [NR-1:0]    oValid_BS,
    input  logic [NR-1:0]    iReady_BS,
    output logic [NR*OW-1:0] oData_BS,
    output logic             oErr
);

    localparam int SW = idx_w(NR);

    lock_state_e   lock_q, lock_d;
    logic [SW-1:0] lock_idx_q, lock_idx_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    logic [SW-1:0] sel, head;
    logic          full, empty, in_hs, out_hs;

    // First valid lane at or after start, wrapping; falls back to start when none is valid.
    function automatic logic [SW-1:0] rr_pick(input logic [NR-1:0] vld, input logic [SW-1:0] start);
        logic [SW-1:0] pick;
        logic          found;
        int            idx;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < NR; k++) begin
            idx = (int'(start) + k) % NR;
            if (!found && vld[idx]) begin
                pick  = SW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign sel       = (lock_q == LOCK_HELD) ? lock_idx_q : rr_pick(iValid_AS, ptr_q);
    assign oValid_NA = iRST && iValid_AS[sel] && !full;
    assign oData_NA  = iData_AS[int'(sel)*IW +: IW];
    assign in_hs     = oValid_NA && iReady_NA;

    always_comb begin
        oReady_AS      = '0;
        oReady_AS[sel] = iRST && iReady_NA && !full;
    end

    // A held offer pins the grant so oData_NA cannot change until it is taken.
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_q;
        case (lock_q)
            LOCK_FREE: begin
                if (oValid_NA && !iReady_NA) begin
                    lock_d     = LOCK_HELD;
                    lock_idx_d = sel;
                end
            end
            LOCK_HELD: begin
                if (in_hs) begin
                    lock_d = LOCK_FREE;
                end
            end
            default: lock_d = LOCK_FREE;
        endcase
        if (in_hs) begin
            ptr_d = (sel == SW'(NR - 1)) ? '0 : sel + SW'(1);
        end
    end

    always_comb begin
        oValid_BS       = '0;
        oValid_BS[head] = iRST && iValid_NB && !empty;
    end

    assign oReady_NB = iRST && !empty && iReady_BS[head];
    assign out_hs    = iValid_NB && oReady_NB;
    assign oData_BS  = {NR{iData_NB}};
    assign err_d     = err_q || (iValid_NB && empty);
    assign oErr      = err_q;

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            lock_q     <= LOCK_FREE;
            lock_idx_q <= '0;
            ptr_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
        end
    end

    neuron_tag_fifo #(
        .DEPTH(TQ),
        .W    (SW)
    ) u_tag_fifo (
        .clk_i  (iCLK),
        .rst_ni (iRST),
        .push_i (in_hs),
        .data_i (sel),
        .pop_i  (out_hs),
        .head_o (head),
        .full_o (full),
        .empty_o(empty)
    );

endmodule

// File: tb/tb_neuron_arbiter.sv
// Directed scenarios plus a randomized scoreboard run for neuron_arbiter (NR=3, TQ=2).
module tb_neuron_arbiter;

    localparam int NR = 3;
    localparam int NP = 4;
    localparam int NC = 4;
    localparam int WD = 4;
    localparam int TQ = 2;
    localparam int IW = NC * ($clog2(NP) + 1 + WD);
    localparam int OW = NC * WD;

    logic             iCLK;
    logic             iRST;
    logic [NR-1:0]    iValid_AS;
    logic [NR-1:0]    oReady_AS;
    logic [NR*IW-1:0] iData_AS;
    logic             oValid_NA;
    logic             iReady_NA;
    logic [IW-1:0]    oData_NA;
    logic             iValid_NB;
    logic             oReady_NB;
    logic [OW-1:0]    iData_NB;
    logic [NR-1:0]    oValid_BS;
    logic [NR-1:0]    iReady_BS;
    logic [NR*OW-1:0] oData_BS;
    logic             oErr;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] rdat [NR];

    // Neuron stand-in: two-deep pipeline that forwards the low OW bits of each accepted beat.
    logic [OW-1:0] nq [$];
    logic          nb_v     = 1'b0;
    logic [OW-1:0] nb_d     = '0;
    int            nb_cnt   = 0;
    logic          nb_gate  = 1'b1;
    logic          force_nb = 1'b0;
    logic          nb_take, nb_give;

    assign iValid_NB = nb_v | force_nb;
    assign iData_NB  = nb_d;
    assign iReady_NA = nb_gate && (nb_cnt < 2);
    assign nb_take   = oValid_NA && iReady_NA;
    assign nb_give   = nb_v && iValid_NB && oReady_NB;

    always @(posedge iCLK) begin
        if (!iRST) begin
            nq.delete();
        end else begin
            if (nb_give) void'(nq.pop_front());
            if (nb_take) nq.push_back(oData_NA[OW-1:0]);
        end
        nb_v   <= (nq.size() != 0);
        nb_d   <= (nq.size() != 0) ? nq[0] : '0;
        nb_cnt <= nq.size();
    end

    always_comb begin
        iData_AS = '0;
        for (int r = 0; r < NR; r++) iData_AS[r*IW +: IW] = rdat[r];
    end

    neuron_arbiter #(
        .NR(NR), .HIDDEN("yes"), .NP(NP), .NC(NC), .WD(WD), .TQ(TQ)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iValid_AS(iValid_AS), .oReady_AS(oReady_AS), .iData_AS(iData_AS),
        .oValid_NA(oValid_NA), .iReady_NA(iReady_NA), .oData_NA(oData_NA),
        .iValid_NB(iValid_NB), .oReady_NB(oReady_NB), .iData_NB(iData_NB),
        .oValid_BS(oValid_BS), .iReady_BS(iReady_BS), .oData_BS(oData_BS),
        .oErr(oErr)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iRST = 1'b0; iValid_AS = '0; iReady_BS = '0; nb_gate = 1'b1; force_nb = 1'b0;
        step(); step();
        iRST = 1'b1;
    endtask

    task automatic test_reset();
        iRST = 1'b0; iValid_AS = '1; iReady_BS = '1; force_nb = 1'b1; nb_gate = 1'b1;
        for (int r = 0; r < NR; r++) rdat[r] = IW'(r + 1);
        step(); step(); #1;
        checks++; if (oValid_NA !== 1'b0) begin errors++; $display("FAIL reset_vld_na: got %0b expected 0", oValid_NA); end
        checks++; if (oReady_AS !== '0) begin errors++; $display("FAIL reset_rdy_as: got %0b expected 0", oReady_AS); end
        checks++; if (oValid_BS !== '0) begin errors++; $display("FAIL reset_vld_bs: got %0b expected 0", oValid_BS); end
        checks++; if (oReady_NB !== 1'b0) begin errors++; $display("FAIL reset_rdy_nb: got %0b expected 0", oReady_NB); end
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", oErr); end
        force_nb = 1'b0;
    endtask

    task automatic test_alternate();
        logic [NR-1:0] e;
        do_reset();
        iValid_AS = 3'b011; iReady_BS = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            e = '0; e[k % 2] = 1'b1;
            checks++; if (oReady_AS !== e) begin errors++; $display("FAIL alt_grant[%0d]: got %0b expected %0b", k, oReady_AS, e); end
            if (k > 0) begin
                e = '0; e[(k - 1) % 2] = 1'b1;
                checks++; if (oValid_BS !== e) begin errors++; $display("FAIL alt_result[%0d]: got %0b expected %0b", k, oValid_BS, e); end
            end
            step();
        end
    endtask

    task automatic test_lock();
        do_reset();
        rdat[0] = 28'h0AA_0000; rdat[1] = 28'h0BB_1111;
        iValid_AS = 3'b010; iReady_BS = '1; nb_gate = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (oValid_NA !== 1'b1) begin errors++; $display("FAIL lock_vld[%0d]: got %0b expected 1", k, oValid_NA); end
            checks++; if (oData_NA !== rdat[1]) begin errors++; $display("FAIL lock_data[%0d]: got %0h expected %0h", k, oData_NA, rdat[1]); end
            step();
            iValid_AS = 3'b011;
        end
        nb_gate = 1'b1; #1;
        checks++; if (oReady_AS !== 3'b010) begin errors++; $display("FAIL lock_release: got %0b expected 010", oReady_AS); end
        step(); #1;
        checks++; if (oReady_AS !== 3'b001) begin errors++; $display("FAIL lock_next_grant: got %0b expected 001", oReady_AS); end
        checks++; if (oData_NA !== rdat[0]) begin errors++; $display("FAIL lock_next_data: got %0h expected %0h", oData_NA, rdat[0]); end
        step();
    endtask

    task automatic test_full();
        do_reset();
        iValid_AS = 3'b011; iReady_BS = '0;
        #1;
        checks++; if (oReady_AS !== 3'b001) begin errors++; $display("FAIL full_hs0: got %0b expected 001", oReady_AS); end
        step(); #1;
        checks++; if (oReady_AS !== 3'b010) begin errors++; $display("FAIL full_hs1: got %0b expected 010", oReady_AS); end
        step(); #1;
        checks++; if (oValid_NA !== 1'b0) begin errors++; $display("FAIL full_block: got %0b expected 0", oValid_NA); end
        checks++; if (oValid_BS !== 3'b001) begin errors++; $display("FAIL full_head: got %0b expected 001", oValid_BS); end
        step();
        iReady_BS = 3'b001; #1;
        checks++; if (oReady_NB !== 1'b1) begin errors++; $display("FAIL full_pop: got %0b expected 1", oReady_NB); end
        checks++; if (oValid_NA !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %0b expected 0", oValid_NA); end
        step();
        iReady_BS = '0; #1;
        checks++; if (oReady_AS !== 3'b001) begin errors++; $display("FAIL full_refill: got %0b expected 001", oReady_AS); end
        checks++; if (oValid_BS !== 3'b010) begin errors++; $display("FAIL full_head2: got %0b expected 010", oValid_BS); end
        step(); #1;
        checks++; if (oValid_NA !== 1'b0) begin errors++; $display("FAIL full_again: got %0b expected 0", oValid_NA); end
    endtask

    task automatic test_err();
        iRST = 1'b0; iValid_AS = '0; iReady_BS = '1; force_nb = 1'b1;
        step(); step();
        iRST = 1'b1; #1;
        checks++; if (oReady_NB !== 1'b0) begin errors++; $display("FAIL err_stall: got %0b expected 0", oReady_NB); end
        checks++; if (oValid_BS !== '0) begin errors++; $display("FAIL err_vld_bs: got %0b expected 0", oValid_BS); end
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL err_early: got %0b expected 0", oErr); end
        step();
        force_nb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (oErr !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d]: got %0b expected 1", k, oErr); end
            step();
        end
        iRST = 1'b0;
        step(); #1;
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL err_cleared: got %0b expected 0", oErr); end
    endtask

    task automatic test_reset_flight();
        do_reset();
        iValid_AS = 3'b011; iReady_BS = '0;
        step(); step();
        iRST = 1'b0; iValid_AS = 3'b111; iReady_BS = '1;
        step(); #1;
        checks++; if (oValid_NA !== 1'b0) begin errors++; $display("FAIL rst_fl_vld_na: got %0b expected 0", oValid_NA); end
        checks++; if (oReady_AS !== '0) begin errors++; $display("FAIL rst_fl_rdy_as: got %0b expected 0", oReady_AS); end
        checks++; if (oValid_BS !== '0) begin errors++; $display("FAIL rst_fl_vld_bs: got %0b expected 0", oValid_BS); end
        checks++; if (oReady_NB !== 1'b0) begin errors++; $display("FAIL rst_fl_rdy_nb: got %0b expected 0", oReady_NB); end
        iRST = 1'b1; #1;
        checks++; if (oReady_AS !== 3'b001) begin errors++; $display("FAIL rst_fl_first_grant: got %0b expected 001", oReady_AS); end
        checks++; if (oValid_BS !== '0) begin errors++; $display("FAIL rst_fl_tags_gone: got %0b expected 0", oValid_BS); end
        step();
    endtask

    task automatic test_random(input int ncyc);
        int  tagq [$];
        int  ptr, lidx, sel, h;
        bit  locked, err, stop, done, full, in_hs, out_hs, exp_vna, exp_rnb;
        bit  pend [NR];
        int  issued [NR], deliv [NR], waitc [NR];
        logic [NR-1:0] exp_vbs;
        ptr = 0; lidx = 0; locked = 0; err = 0; done = 0;
        for (int r = 0; r < NR; r++) begin pend[r] = 0; issued[r] = 0; deliv[r] = 0; waitc[r] = 0; end
        do_reset();
        for (int cyc = 0; cyc < ncyc + 400 && !done; cyc++) begin
            stop = (cyc >= ncyc);
            for (int r = 0; r < NR; r++) begin
                if (!pend[r] && !stop && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1;
                    rdat[r] = {12'($urandom), 2'(r), 14'(issued[r])};
                    issued[r]++;
                end
                iValid_AS[r] = pend[r];
            end
            iReady_BS = stop ? '1 : NR'($urandom);
            nb_gate   = stop ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            full = (tagq.size() == TQ);
            sel  = ptr;
            if (locked) sel = lidx;
            else begin
                for (int k = NR - 1; k >= 0; k--) if (pend[(ptr + k) % NR]) sel = (ptr + k) % NR;
            end
            exp_vna = pend[sel] && !full;
            in_hs   = exp_vna && iReady_NA;
            checks++; if (oValid_NA !== exp_vna) begin errors++; $display("FAIL rnd_vld_na c%0d: got %0b expected %0b", cyc, oValid_NA, exp_vna); end
            if (exp_vna) begin
                checks++; if (oData_NA !== rdat[sel]) begin errors++; $display("FAIL rnd_data_na c%0d: got %0h expected %0h", cyc, oData_NA, rdat[sel]); end
            end
            for (int r = 0; r < NR; r++) if (pend[r]) begin
                checks++;
                if (oReady_AS[r] !== (r == sel && iReady_NA && !full)) begin
                    errors++; $display("FAIL rnd_rdy_as c%0d lane %0d: got %0b expected %0b", cyc, r, oReady_AS[r], (r == sel && iReady_NA && !full));
                end
            end
            h = (tagq.size() != 0) ? tagq[0] : 0;
            exp_vbs = '0;
            if (iValid_NB && tagq.size() != 0) exp_vbs[h] = 1'b1;
            exp_rnb = (tagq.size() != 0) && iReady_BS[h];
            out_hs  = iValid_NB && exp_rnb;
            checks++; if (oValid_BS !== exp_vbs) begin errors++; $display("FAIL rnd_vld_bs c%0d: got %0b expected %0b", cyc, oValid_BS, exp_vbs); end
            checks++; if (oReady_NB !== exp_rnb) begin errors++; $display("FAIL rnd_rdy_nb c%0d: got %0b expected %0b", cyc, oReady_NB, exp_rnb); end
            checks++; if (oErr !== err) begin errors++; $display("FAIL rnd_err c%0d: got %0b expected %0b", cyc, oErr, err); end
            if (out_hs) begin
                checks++; if (iData_NB[15:14] !== 2'(h)) begin errors++; $display("FAIL rnd_route c%0d: got lane %0d expected %0d", cyc, iData_NB[15:14], h); end
                checks++; if (iData_NB[13:0] !== 14'(deliv[h])) begin errors++; $display("FAIL rnd_order c%0d lane %0d: got seq %0d expected %0d", cyc, h, iData_NB[13:0], deliv[h]); end
                checks++; if (oData_BS !== {NR{iData_NB}}) begin errors++; $display("FAIL rnd_data_bs c%0d: got %0h expected %0h", cyc, oData_BS, {NR{iData_NB}}); end
                deliv[h]++;
            end
            if (iValid_NB && tagq.size() == 0) err = 1;
            if (in_hs) begin
                tagq.push_back(sel);
                pend[sel] = 0; ptr = (sel + 1) % NR; locked = 0; waitc[sel] = 0;
                for (int r = 0; r < NR; r++) if (r != sel && pend[r]) begin
                    waitc[r]++;
                    checks++; if (waitc[r] > NR) begin errors++; $display("FAIL rnd_starve c%0d lane %0d: got %0d waits expected <= %0d", cyc, r, waitc[r], NR); end
                end
            end else if (exp_vna) begin
                locked = 1; lidx = sel;
            end
            if (out_hs) void'(tagq.pop_front());
            done = stop && tagq.size() == 0 && !pend[0] && !pend[1] && !pend[2];
            step();
        end
        checks++; if (!done) begin errors++; $display("FAIL rnd_drain: got %0d tags in flight expected 0", tagq.size()); end
        for (int r = 0; r < NR; r++) begin
            checks++; if (deliv[r] != issued[r]) begin errors++; $display("FAIL rnd_count lane %0d: got %0d delivered expected %0d", r, deliv[r], issued[r]); end
        end
    endtask

    initial begin
        iRST = 1'b0; iValid_AS = '0; iReady_BS = '0;
        for (int r = 0; r < NR; r++) rdat[r] = '0;
        test_reset();
        test_alternate();
        test_lock();
        test_full();
        test_err();
        test_reset_flight();
        test_random(10000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
